// File: rtl/sctrl_read_arbiter.sv
// sctrl_read_arbiter: two-requester read arbiter and burst sequencer for the
// sensor_ctrl read port. Requester 0 is the AXI slave wrapper, requester 1 is
// the DMA drain engine. One burst is granted at a time; each beat takes a
// FETCH cycle (address out, data captured) and a RESP cycle (registered data
// offered to the owner until accepted).
//
// Build option:
//   SCTRL_ARB_FIXED_PRI_EN - when defined, requester 0 always wins a tie and
//                            no round-robin pointer exists. Default is
//                            round-robin arbitration.
module sctrl_read_arbiter #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [1:0]            req_valid,
    input  logic [2*ADDR_W-1:0]   req_addr,
    input  logic [2*LEN_W-1:0]    req_len,
    output logic [1:0]            req_ready,
    output logic [1:0]            rsp_valid,
    output logic [DATA_W-1:0]     rsp_data,
    output logic                  rsp_last,
    input  logic [1:0]            rsp_ready,
    input  logic                  hold,
    output logic [ADDR_W-1:0]     sctrl_addr,
    input  logic [DATA_W-1:0]     sctrl_out,
    output logic                  busy,
    output logic                  owner
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic                owner_q;
    logic [ADDR_W-1:0]   base_q;
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    beat_q;
    logic [DATA_W-1:0]   data_q;

    logic                win;
    logic                grant;
    logic                handshake;
    logic                last_beat;
    logic [ADDR_W-1:0]   fetch_addr;

    // Address wraps naturally modulo 2^ADDR_W, so bursts may cross the top
    // of the sensor buffer.
    assign fetch_addr = base_q + ADDR_W'(beat_q);
    assign last_beat  = (beat_q == len_q);
    assign handshake  = (state_q == RESP) && rsp_ready[owner_q];

`ifdef SCTRL_ARB_FIXED_PRI_EN
    assign win = ~req_valid[0];
`else
    logic rr_q;

    assign win = (&req_valid) ? rr_q : req_valid[1];

    // Round-robin pointer moves to the other requester when a burst finishes.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rr_q <= 1'b0;
        end else if (handshake && last_beat) begin
            rr_q <= ~owner_q;
        end
    end
`endif

    // Next-state logic; grants only leave IDLE while hold is low.
    always_comb begin
        state_d = state_q;
        grant   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!hold && (|req_valid)) begin
                    grant   = 1'b1;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = RESP;
            end
            RESP: begin
                if (handshake) begin
                    state_d = last_beat ? IDLE : FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, burst context and data register; reset drops any burst in flight.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            beat_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                owner_q <= win;
                base_q  <= win ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
                len_q   <= win ? req_len[LEN_W +: LEN_W] : req_len[0 +: LEN_W];
                beat_q  <= '0;
            end
            if (state_q == FETCH) begin
                data_q <= sctrl_out;
            end
            if (handshake && !last_beat) begin
                beat_q <= beat_q + 1'b1;
            end
        end
    end

    assign req_ready  = grant ? (win ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid  = (state_q == RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_data   = data_q;
    assign rsp_last   = (state_q == RESP) && last_beat;
    assign sctrl_addr = (state_q == IDLE) ? '0 : fetch_addr;
    assign busy       = (state_q != IDLE);
    assign owner      = owner_q;

endmodule

// File: tb/tb_sctrl_read_arbiter.sv
// tb_sctrl_read_arbiter: directed bench for sctrl_read_arbiter in its default
// round-robin build. The sensor buffer is modelled as data = address * 16.
module tb_sctrl_read_arbiter;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;

    logic                clk;
    logic                resetn;
    logic [1:0]          req_valid;
    logic [2*ADDR_W-1:0] req_addr;
    logic [2*LEN_W-1:0]  req_len;
    logic [1:0]          req_ready;
    logic [1:0]          rsp_valid;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_last;
    logic [1:0]          rsp_ready;
    logic                hold;
    logic [ADDR_W-1:0]   sctrl_addr;
    logic [DATA_W-1:0]   sctrl_out;
    logic                busy;
    logic                owner;

    int compared;
    int mismatched;

    sctrl_read_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_len    (req_len),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .rsp_last   (rsp_last),
        .rsp_ready  (rsp_ready),
        .hold       (hold),
        .sctrl_addr (sctrl_addr),
        .sctrl_out  (sctrl_out),
        .busy       (busy),
        .owner      (owner)
    );

    // Sensor buffer model: each word holds its own address times 16.
    assign sctrl_out = {{(DATA_W-ADDR_W-4){1'b0}}, sctrl_addr, 4'b0000};

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic [1:0] v,
                                 input logic [ADDR_W-1:0] a0,
                                 input logic [ADDR_W-1:0] a1,
                                 input logic [LEN_W-1:0] l0,
                                 input logic [LEN_W-1:0] l1,
                                 input logic h,
                                 input logic [1:0] rdy);
        @(posedge clk);
        #2;
        req_valid = v;
        req_addr  = {a1, a0};
        req_len   = {l1, l0};
        hold      = h;
        rsp_ready = rdy;
        #1;
    endtask

    task automatic checkOutput(input string tag,
                               input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence.
    initial begin
        compared   = 0;
        mismatched = 0;
        resetn     = 1'b1;
        req_valid  = 2'b00;
        req_addr   = '0;
        req_len    = '0;
        hold       = 1'b0;
        rsp_ready  = 2'b00;
        #1;
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        checkOutput("reset_req_ready", 32'(req_ready), 32'h0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("reset_rsp_data", rsp_data, 32'h0);
        checkOutput("reset_rsp_last", 32'(rsp_last), 32'h0);
        checkOutput("reset_sctrl_addr", 32'(sctrl_addr), 32'h0);
        checkOutput("reset_busy", 32'(busy), 32'h0);
        checkOutput("reset_owner", 32'(owner), 32'h0);
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // Single beat from requester 0.
        applyStimulus(2'b01, 6'd5, 6'd0, 4'd0, 4'd0, 1'b0, 2'b01);
        checkOutput("t1_req_ready", 32'(req_ready), 32'h1);
        checkOutput("t1_idle_busy", 32'(busy), 32'h0);
        applyStimulus(2'b00, 6'd5, 6'd0, 4'd0, 4'd0, 1'b0, 2'b01);
        checkOutput("t1_fetch_busy", 32'(busy), 32'h1);
        checkOutput("t1_fetch_addr", 32'(sctrl_addr), 32'd5);
        checkOutput("t1_fetch_rsp_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b00, 6'd5, 6'd0, 4'd0, 4'd0, 1'b0, 2'b01);
        checkOutput("t1_rsp_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t1_rsp_data", rsp_data, 32'h50);
        checkOutput("t1_rsp_last", 32'(rsp_last), 32'h1);
        applyStimulus(2'b00, 6'd5, 6'd0, 4'd0, 4'd0, 1'b0, 2'b00);
        checkOutput("t1_done_busy", 32'(busy), 32'h0);
        checkOutput("t1_done_rsp_valid", 32'(rsp_valid), 32'h0);

        // Fresh reset so the round-robin pointer starts at requester 0.
        @(posedge clk);
        #2;
        resetn = 1'b0;
        @(posedge clk);
        #2;
        resetn = 1'b1;

        // Both valid, two beats each: requester 0 then requester 1.
        applyStimulus(2'b11, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_grant0", 32'(req_ready), 32'h1);
        applyStimulus(2'b11, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_b0_addr", 32'(sctrl_addr), 32'd10);
        checkOutput("t2_b0_no_ready", 32'(req_ready), 32'h0);
        applyStimulus(2'b11, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_b0_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t2_b0_data", rsp_data, 32'hA0);
        checkOutput("t2_b0_last", 32'(rsp_last), 32'h0);
        applyStimulus(2'b11, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_b1_addr", 32'(sctrl_addr), 32'd11);
        applyStimulus(2'b11, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_b1_data", rsp_data, 32'hB0);
        checkOutput("t2_b1_last", 32'(rsp_last), 32'h1);
        applyStimulus(2'b11, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_grant1", 32'(req_ready), 32'h2);
        checkOutput("t2_gap_busy", 32'(busy), 32'h0);
        applyStimulus(2'b00, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_r1_addr0", 32'(sctrl_addr), 32'd20);
        checkOutput("t2_r1_owner", 32'(owner), 32'h1);
        applyStimulus(2'b00, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_r1_valid", 32'(rsp_valid), 32'h2);
        checkOutput("t2_r1_data0", rsp_data, 32'h140);
        applyStimulus(2'b00, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_r1_addr1", 32'(sctrl_addr), 32'd21);
        applyStimulus(2'b00, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b11);
        checkOutput("t2_r1_data1", rsp_data, 32'h150);
        checkOutput("t2_r1_last", 32'(rsp_last), 32'h1);
        applyStimulus(2'b00, 6'd10, 6'd20, 4'd1, 4'd1, 1'b0, 2'b00);
        checkOutput("t2_done_busy", 32'(busy), 32'h0);

        // Requester 1 wrapping burst, with a stall and hold raised mid-burst.
        applyStimulus(2'b10, 6'd0, 6'd62, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t3_grant", 32'(req_ready), 32'h2);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t3_addr62", 32'(sctrl_addr), 32'd62);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t3_data62", rsp_data, 32'h3E0);
        checkOutput("t3_last0", 32'(rsp_last), 32'h0);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b10);
        checkOutput("t3_addr63", 32'(sctrl_addr), 32'd63);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b01);
            checkOutput("t3_stall_valid", 32'(rsp_valid), 32'h2);
            checkOutput("t3_stall_data", rsp_data, 32'h3F0);
            checkOutput("t3_stall_last", 32'(rsp_last), 32'h0);
        end
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b10);
        checkOutput("t3_release_data", rsp_data, 32'h3F0);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b10);
        checkOutput("t3_addr0", 32'(sctrl_addr), 32'd0);
        checkOutput("t3_fetch_valid", 32'(rsp_valid), 32'h0);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b10);
        checkOutput("t3_data0", rsp_data, 32'h0);
        checkOutput("t3_last2", 32'(rsp_last), 32'h0);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b10);
        checkOutput("t3_addr1", 32'(sctrl_addr), 32'd1);
        applyStimulus(2'b00, 6'd0, 6'd62, 4'd0, 4'd3, 1'b1, 2'b10);
        checkOutput("t3_data1", rsp_data, 32'h10);
        checkOutput("t3_last3", 32'(rsp_last), 32'h1);

        // Hold blocks new grants once the burst has finished.
        applyStimulus(2'b11, 6'd40, 6'd62, 4'd0, 4'd3, 1'b1, 2'b11);
        checkOutput("t4_hold_busy", 32'(busy), 32'h0);
        checkOutput("t4_hold_ready", 32'(req_ready), 32'h0);
        applyStimulus(2'b11, 6'd40, 6'd62, 4'd0, 4'd3, 1'b1, 2'b11);
        checkOutput("t4_hold_ready2", 32'(req_ready), 32'h0);
        checkOutput("t4_hold_busy2", 32'(busy), 32'h0);
        applyStimulus(2'b11, 6'd40, 6'd62, 4'd0, 4'd3, 1'b0, 2'b11);
        checkOutput("t4_release_grant", 32'(req_ready), 32'h1);
        applyStimulus(2'b00, 6'd40, 6'd62, 4'd0, 4'd3, 1'b0, 2'b11);
        checkOutput("t4_addr40", 32'(sctrl_addr), 32'd40);
        applyStimulus(2'b00, 6'd40, 6'd62, 4'd0, 4'd3, 1'b0, 2'b11);
        checkOutput("t4_valid", 32'(rsp_valid), 32'h1);
        checkOutput("t4_data", rsp_data, 32'h280);
        applyStimulus(2'b00, 6'd40, 6'd62, 4'd0, 4'd3, 1'b0, 2'b00);
        checkOutput("t4_done_busy", 32'(busy), 32'h0);
        applyStimulus(2'b01, 6'd40, 6'd62, 4'd0, 4'd3, 1'b1, 2'b00);
        checkOutput("t4_same_cycle_ready", 32'(req_ready), 32'h0);
        applyStimulus(2'b00, 6'd40, 6'd62, 4'd0, 4'd3, 1'b1, 2'b00);
        checkOutput("t4_same_cycle_busy", 32'(busy), 32'h0);

        // Reset during beat 2 of a 4-beat burst from requester 1.
        applyStimulus(2'b10, 6'd0, 6'd30, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t5_grant", 32'(req_ready), 32'h2);
        applyStimulus(2'b00, 6'd0, 6'd30, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t5_addr30", 32'(sctrl_addr), 32'd30);
        applyStimulus(2'b00, 6'd0, 6'd30, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t5_data30", rsp_data, 32'h1E0);
        applyStimulus(2'b00, 6'd0, 6'd30, 4'd0, 4'd3, 1'b0, 2'b10);
        checkOutput("t5_addr31", 32'(sctrl_addr), 32'd31);
        applyStimulus(2'b00, 6'd0, 6'd30, 4'd0, 4'd3, 1'b0, 2'b00);
        checkOutput("t5_beat2_valid", 32'(rsp_valid), 32'h2);
        checkOutput("t5_beat2_owner", 32'(owner), 32'h1);
        #1;
        resetn = 1'b0;
        #1;
        checkOutput("t5_rst_req_ready", 32'(req_ready), 32'h0);
        checkOutput("t5_rst_rsp_valid", 32'(rsp_valid), 32'h0);
        checkOutput("t5_rst_rsp_data", rsp_data, 32'h0);
        checkOutput("t5_rst_rsp_last", 32'(rsp_last), 32'h0);
        checkOutput("t5_rst_sctrl_addr", 32'(sctrl_addr), 32'h0);
        checkOutput("t5_rst_busy", 32'(busy), 32'h0);
        checkOutput("t5_rst_owner", 32'(owner), 32'h0);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        applyStimulus(2'b11, 6'd7, 6'd9, 4'd0, 4'd0, 1'b0, 2'b11);
        checkOutput("t5_post_busy", 32'(busy), 32'h0);
        checkOutput("t5_post_rr_grant", 32'(req_ready), 32'h1);
        applyStimulus(2'b00, 6'd7, 6'd9, 4'd0, 4'd0, 1'b0, 2'b11);
        checkOutput("t5_post_addr", 32'(sctrl_addr), 32'd7);
        checkOutput("t5_post_owner", 32'(owner), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
